// File: rtl/datapath_if.sv
// Control/data bundle between the control unit (master) and the bus datapath (slave).
// Strobes and memory data flow master->slave; register contents, bus and ALU result flow back.
interface datapath_if #(parameter int WIDTH = 32);
  // Bus source enables
  logic PCout, Zlowout, MDRout, R2out, R4out;
  // Register load enables
  logic PCin, MARin, MDRin, IRin, Yin, Zin, R2in, R4in, R5in;
  // MDR source select and one-hot ALU op strobes
  logic read, IncPC;
  logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
  logic [WIDTH-1:0] Mdatain;

  // Register contents and combinational results
  logic [WIDTH-1:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [WIDTH-1:0] R8, R9, R10, R11, R12, R13, R14, R15;
  logic [WIDTH-1:0] PC, IR, MDR, Hi, Lo, MAR;
  logic [WIDTH-1:0] bus_mux_out;
  logic [2*WIDTH-1:0] Z, ALUout;

  modport master (
    output PCout, Zlowout, MDRout, R2out, R4out,
    output PCin, MARin, MDRin, IRin, Yin, Zin, R2in, R4in, R5in,
    output read, IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
    output Mdatain,
    input  R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15,
    input  PC, IR, MDR, Hi, Lo, MAR, bus_mux_out, Z, ALUout
  );

  modport slave (
    input  PCout, Zlowout, MDRout, R2out, R4out,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, R2in, R4in, R5in,
    input  read, IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
    input  Mdatain,
    output R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15,
    output PC, IR, MDR, Hi, Lo, MAR, bus_mux_out, Z, ALUout
  );
endinterface

// File: rtl/datapath.sv
// Single-bus CPU datapath: shared 32-bit bus, Y/bus ALU into 64-bit Z, strobe-driven register loads.
// MAR has no architectural output of its own; it is visible through the interface for observation.
module datapath #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  datapath_if.slave dp
);

  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
  logic [WIDTH-1:0]   r2_q, r2_d, r4_q, r4_d, r5_q, r5_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] rot;
  logic [4:0]         sh;

  // Fixed-priority bus source select; nothing enabled leaves the bus at zero.
  always_comb begin
    bus = '0;
    if (dp.PCout)        bus = pc_q;
    else if (dp.Zlowout) bus = z_q[WIDTH-1:0];
    else if (dp.MDRout)  bus = mdr_q;
    else if (dp.R2out)   bus = r2_q;
    else if (dp.R4out)   bus = r4_q;
  end

  // ALU: A is Y, B is the bus. Only ADD can set anything in the upper word (its carry).
  // Rotates shift a doubled copy of A so the wrapped bits fall into the kept half.
  always_comb begin
    alu = '0;
    sum = '0;
    rot = '0;
    sh  = bus[4:0];
    if (dp.IncPC) begin
      alu[WIDTH-1:0] = bus + WIDTH'(1);
    end else if (dp.ADD) begin
      sum            = {1'b0, y_q} + {1'b0, bus};
      alu[WIDTH:0]   = sum;
    end else if (dp.SUB) begin
      alu[WIDTH-1:0] = y_q - bus;
    end else if (dp.AND) begin
      alu[WIDTH-1:0] = y_q & bus;
    end else if (dp.OR) begin
      alu[WIDTH-1:0] = y_q | bus;
    end else if (dp.SHR) begin
      alu[WIDTH-1:0] = y_q >> sh;
    end else if (dp.SHL) begin
      alu[WIDTH-1:0] = y_q << sh;
    end else if (dp.ROR) begin
      rot            = {y_q, y_q} >> sh;
      alu[WIDTH-1:0] = rot[WIDTH-1:0];
    end else if (dp.ROL) begin
      rot            = {y_q, y_q} << sh;
      alu[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
    end else if (dp.NEG) begin
      alu[WIDTH-1:0] = '0 - bus;
    end else if (dp.NOT) begin
      alu[WIDTH-1:0] = ~bus;
    end
  end

  always_comb begin
    pc_d  = dp.PCin  ? bus : pc_q;
    ir_d  = dp.IRin  ? bus : ir_q;
    mar_d = dp.MARin ? bus : mar_q;
    mdr_d = dp.MDRin ? (dp.read ? dp.Mdatain : bus) : mdr_q;
    y_d   = dp.Yin   ? bus : y_q;
    z_d   = dp.Zin   ? alu : z_q;
    r2_d  = dp.R2in  ? bus : r2_q;
    r4_d  = dp.R4in  ? bus : r4_q;
    r5_d  = dp.R5in  ? bus : r5_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      r2_q  <= '0;
      r4_q  <= '0;
      r5_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      r2_q  <= r2_d;
      r4_q  <= r4_d;
      r5_q  <= r5_d;
    end
  end

  // Registers without a load strobe can never leave their reset value.
  assign dp.R0  = '0;
  assign dp.R1  = '0;
  assign dp.R2  = r2_q;
  assign dp.R3  = '0;
  assign dp.R4  = r4_q;
  assign dp.R5  = r5_q;
  assign dp.R6  = '0;
  assign dp.R7  = '0;
  assign dp.R8  = '0;
  assign dp.R9  = '0;
  assign dp.R10 = '0;
  assign dp.R11 = '0;
  assign dp.R12 = '0;
  assign dp.R13 = '0;
  assign dp.R14 = '0;
  assign dp.R15 = '0;
  assign dp.Hi  = '0;
  assign dp.Lo  = '0;

  assign dp.PC          = pc_q;
  assign dp.IR          = ir_q;
  assign dp.MDR         = mdr_q;
  assign dp.MAR         = mar_q;
  assign dp.Z           = z_q;
  assign dp.bus_mux_out = bus;
  assign dp.ALUout      = alu;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the bus datapath: register transfers, fetch, ALU ops, carry and async reset.
module tb_datapath;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  datapath_if #(.WIDTH(32)) dp ();

  datapath #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_ctrl();
    dp.PCout = 0; dp.Zlowout = 0; dp.MDRout = 0; dp.R2out = 0; dp.R4out = 0;
    dp.PCin = 0; dp.MARin = 0; dp.MDRin = 0; dp.IRin = 0; dp.Yin = 0;
    dp.Zin = 0; dp.R2in = 0; dp.R4in = 0; dp.R5in = 0;
    dp.read = 0; dp.IncPC = 0;
    dp.ADD = 0; dp.SUB = 0; dp.AND = 0; dp.OR = 0; dp.SHR = 0;
    dp.SHL = 0; dp.ROR = 0; dp.ROL = 0; dp.NEG = 0; dp.NOT = 0;
  endtask

  // One clock: strobes set beforehand are sampled, then cleared 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory value straight into MDR.
  task automatic load_mdr(input logic [31:0] val);
    dp.Mdatain = val; dp.read = 1; dp.MDRin = 1;
    cycle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_ctrl();
    dp.Mdatain = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_pc", dp.PC, 0);
    chk("rst_z", dp.Z, 0);
    chk("rst_bus_idle", dp.bus_mux_out, 0);
    chk("rst_alu_idle", dp.ALUout, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Register loads through MDR
    load_mdr(32'd22);
    chk("mdr_load", dp.MDR, 22);
    dp.MDRout = 1; dp.R2in = 1; cycle();
    chk("r2_load", dp.R2, 22);
    load_mdr(32'd24);
    dp.MDRout = 1; dp.R4in = 1; cycle();
    chk("r4_load", dp.R4, 24);
    load_mdr(32'd26);
    dp.MDRout = 1; dp.R5in = 1; cycle();
    chk("r5_load", dp.R5, 26);

    // Fetch
    dp.PCout = 1; dp.MARin = 1; dp.IncPC = 1; dp.Zin = 1;
    #1;
    chk("incpc_comb", dp.ALUout, 64'd1);
    cycle();
    chk("fetch_z", dp.Z, 64'd1);
    chk("fetch_mar", dp.MAR, 0);
    dp.Zlowout = 1; dp.PCin = 1; cycle();
    chk("fetch_pc", dp.PC, 1);
    load_mdr(32'h4A92_0000);
    dp.MDRout = 1; dp.IRin = 1; cycle();
    chk("fetch_ir", dp.IR, 32'h4A92_0000);

    // NEG of R4 into Z then R5
    dp.R2out = 1; dp.Yin = 1; cycle();
    dp.R4out = 1; dp.NEG = 1; dp.Zin = 1; cycle();
    chk("neg_z", dp.Z, 64'h0000_0000_FFFF_FFE8);
    dp.Zlowout = 1; dp.R5in = 1; cycle();
    chk("neg_r5", dp.R5, 32'hFFFF_FFE8);

    // ALU ops with Y=22, bus=R4=24
    dp.R4out = 1;
    dp.ADD = 1; #1; chk("alu_add", dp.ALUout, 64'd46); dp.ADD = 0;
    dp.SUB = 1; #1; chk("alu_sub", dp.ALUout, 64'h0000_0000_FFFF_FFFE); dp.SUB = 0;
    dp.AND = 1; #1; chk("alu_and", dp.ALUout, 64'd16); dp.AND = 0;
    dp.OR  = 1; #1; chk("alu_or", dp.ALUout, 64'd30); dp.OR = 0;
    dp.NOT = 1; #1; chk("alu_not", dp.ALUout, 64'h0000_0000_FFFF_FFE7); dp.NOT = 0;
    dp.ADD = 1; dp.SUB = 1; dp.NOT = 1; #1;
    chk("alu_prio_add_over_sub", dp.ALUout, 64'd46);
    dp.ADD = 0; #1;
    chk("alu_prio_sub_over_not", dp.ALUout, 64'h0000_0000_FFFF_FFFE);
    clear_ctrl(); #1;
    chk("alu_no_strobe", dp.ALUout, 0);
    dp.R4out = 1; dp.AND = 1; dp.Zin = 1; cycle();
    chk("alu_and_into_z", dp.Z, 64'd16);

    // Shifts and rotates with Y=0x80000001, B=1
    load_mdr(32'h8000_0001);
    dp.MDRout = 1; dp.Yin = 1; cycle();
    load_mdr(32'd1);
    dp.MDRout = 1;
    dp.ROL = 1; #1; chk("alu_rol", dp.ALUout, 64'd3); dp.ROL = 0;
    dp.ROR = 1; #1; chk("alu_ror", dp.ALUout, 64'h0000_0000_C000_0000); dp.ROR = 0;
    dp.SHR = 1; #1; chk("alu_shr", dp.ALUout, 64'h0000_0000_4000_0000); dp.SHR = 0;
    dp.SHL = 1; #1; chk("alu_shl", dp.ALUout, 64'd2); dp.SHL = 0;
    clear_ctrl();

    // ADD carry into the upper word
    load_mdr(32'hFFFF_FFFF);
    dp.MDRout = 1; dp.Yin = 1; cycle();
    load_mdr(32'd1);
    dp.MDRout = 1; dp.ADD = 1; dp.Zin = 1; cycle();
    chk("add_carry_z", dp.Z, 64'h0000_0001_0000_0000);

    // Bus priority and hold behaviour
    dp.PCout = 1; dp.MDRout = 1; dp.R2out = 1; #1;
    chk("bus_prio_pc", dp.bus_mux_out, 32'd1);
    dp.PCout = 0; #1;
    chk("bus_prio_mdr", dp.bus_mux_out, 32'd1);
    dp.MDRout = 0; #1;
    chk("bus_prio_r2", dp.bus_mux_out, 32'd22);
    clear_ctrl();
    dp.Zlowout = 1; dp.R4out = 1; #1;
    chk("bus_prio_zlow", dp.bus_mux_out, 32'd0);
    clear_ctrl();
    chk("r2_hold", dp.R2, 22);
    chk("r0_zero", dp.R0, 0);
    chk("hi_zero", dp.Hi, 0);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", dp.PC, 0);
    chk("arst_ir", dp.IR, 0);
    chk("arst_mdr", dp.MDR, 0);
    chk("arst_r2", dp.R2, 0);
    chk("arst_r5", dp.R5, 0);
    chk("arst_z", dp.Z, 0);
    dp.MDRout = 1; #1;
    chk("arst_bus", dp.bus_mux_out, 0);
    dp.Mdatain = 32'h1234_5678; dp.read = 1; dp.MDRin = 1;
    cycle();
    chk("arst_blocks_load", dp.MDR, 0);
    rst_n = 1'b1;
    load_mdr(32'h1234_5678);
    chk("post_rst_load", dp.MDR, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
